// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin arbiter for the FPro MMIO bus.
// Each grant becomes one single-cycle bus transaction (ISSUE), followed by a
// one-cycle ack to the owning master (ACK). Every output comes straight from
// a flop, so no path runs combinationally from an input to an output.
module mmio_bus_arbiter #(
    parameter int AW = 21,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,          // asynchronous, active low
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wr_data,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rd_data,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wr_data,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rd_data,
    output logic          mmio_cs,
    output logic          mmio_wr,
    output logic          mmio_rd,
    output logic [AW-1:0] mmio_addr,
    output logic [DW-1:0] mmio_wr_data,
    input  logic [DW-1:0] mmio_rd_data,
    output logic [1:0]    grant,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d;          // 0: m0 wins a tie, 1: m1 wins a tie
    logic [1:0]    grant_q, grant_d;
    logic          busy_q, busy_d;
    logic          cs_q, cs_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    ack_q, ack_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;

    // Winner of the current IDLE arbitration (1 = m1).
    logic          pick_m1;

    // Next-state, command latch and strobe computation for the whole FSM.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = 2'b00;
        pick_m1 = (m0_req && m1_req) ? rr_q : m1_req;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // Command fields are captured here only; later changes
                    // on the master side do not reach the bus.
                    grant_d = pick_m1 ? 2'b10 : 2'b01;
                    cs_d    = 1'b1;
                    wr_d    = pick_m1 ? m1_wr : m0_wr;
                    rd_d    = pick_m1 ? ~m1_wr : ~m0_wr;
                    addr_d  = pick_m1 ? m1_addr : m0_addr;
                    wdata_d = pick_m1 ? m1_wr_data : m0_wr_data;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ack_d   = grant_q;
                state_d = ACK;
            end
            ACK: begin
                // Hand the tie-break to whichever master was not just served.
                rr_d    = grant_q[0];
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Read-data capture: only the owner's register, only on a read bus cycle.
    always_comb begin
        rd0_d = rd0_q;
        rd1_d = rd1_q;
        if (rd_q && grant_q[0]) rd0_d = mmio_rd_data;
        if (rd_q && grant_q[1]) rd1_d = mmio_rd_data;
    end

    // State register; reset aborts any transaction in flight without an ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 2'b00;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    assign mmio_cs      = cs_q;
    assign mmio_wr      = wr_q;
    assign mmio_rd      = rd_q;
    assign mmio_addr    = addr_q;
    assign mmio_wr_data = wdata_q;
    assign grant        = grant_q;
    assign busy         = busy_q;
    assign m0_ack       = ack_q[0];
    assign m1_ack       = ack_q[1];
    assign m0_rd_data   = rd0_q;
    assign m1_rd_data   = rd1_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Self-checking bench for mmio_bus_arbiter: a transaction-level model is
// compared against the DUT on every falling clock edge, and directed
// scenarios add literal expectations at fixed cycle offsets.
module tb_mmio_bus_arbiter;
    localparam int AW = 21;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wr_data = '0, m1_wr_data = '0;
    logic          m0_ack, m1_ack, mmio_cs, mmio_wr, mmio_rd, busy;
    logic [DW-1:0] m0_rd_data, m1_rd_data, mmio_wr_data, mmio_rd_data;
    logic [AW-1:0] mmio_addr;
    logic [1:0]    grant;
    logic [DW-1:0] slave_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Slave returns slave_data only while strobed; garbage otherwise so a
    // capture on the wrong cycle shows up.
    assign mmio_rd_data = (mmio_cs && mmio_rd) ? slave_data : 32'hDEAD_BEEF;

    mmio_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
        .grant(grant), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // owner: -1 when nobody holds the bus; age counts cycles since the grant
    // (1 = the bus cycle, 2 = the completion cycle).
    int            md_owner = -1;
    int            md_age   = 0;
    int            md_pref  = 0;
    logic          md_wr    = 0;
    logic [AW-1:0] md_addr  = '0;
    logic [DW-1:0] md_wdata = '0;
    logic [DW-1:0] md_rd [2] = '{default: '0};
    int            pick;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_owner <= -1;
            md_age   <= 0;
            md_pref  <= 0;
            md_addr  <= '0;
            md_wdata <= '0;
            md_wr    <= 1'b0;
            md_rd[0] <= '0;
            md_rd[1] <= '0;
        end else if (md_owner >= 0 && md_age == 1) begin
            if (!md_wr) md_rd[md_owner] <= slave_data;
            md_age <= 2;
        end else if (md_owner >= 0) begin
            md_pref  <= 1 - md_owner;
            md_owner <= -1;
            md_age   <= 0;
        end else if (m0_req || m1_req) begin
            if (m0_req && m1_req) pick = md_pref;
            else                  pick = m1_req ? 1 : 0;
            md_owner <= pick;
            md_age   <= 1;
            md_wr    <= (pick == 1) ? m1_wr : m0_wr;
            md_addr  <= (pick == 1) ? m1_addr : m0_addr;
            md_wdata <= (pick == 1) ? m1_wr_data : m0_wr_data;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic on_bus;
        on_bus = (md_owner >= 0) && (md_age == 1);
        chk("mdl_cs",    {31'd0, mmio_cs}, {31'd0, on_bus});
        chk("mdl_wr",    {31'd0, mmio_wr}, {31'd0, on_bus && md_wr});
        chk("mdl_rd",    {31'd0, mmio_rd}, {31'd0, on_bus && !md_wr});
        chk("mdl_addr",  {11'd0, mmio_addr}, {11'd0, md_addr});
        chk("mdl_wdata", mmio_wr_data, md_wdata);
        chk("mdl_grant", {30'd0, grant},
            (md_owner < 0) ? 32'd0 : ((md_owner == 1) ? 32'd2 : 32'd1));
        chk("mdl_busy",  {31'd0, busy}, {31'd0, md_owner >= 0});
        chk("mdl_ack0",  {31'd0, m0_ack}, {31'd0, md_owner == 0 && md_age == 2});
        chk("mdl_ack1",  {31'd0, m1_ack}, {31'd0, md_owner == 1 && md_age == 2});
        chk("mdl_rd0",   m0_rd_data, md_rd[0]);
        chk("mdl_rd1",   m1_rd_data, md_rd[1]);
    end

    // Advance to 2 time units after the next rising edge.
    task automatic next_cycle(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state, checked while reset is held low.
        next_cycle(2);
        chk("rst_cs", {31'd0, mmio_cs}, 32'd0);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr", {11'd0, mmio_addr}, 32'd0);
        chk("rst_rd0", m0_rd_data, 32'd0);
        reset = 1'b1;
        next_cycle();

        // m0 write 0xC0 <- 0x5, m1 idle.
        m0_req = 1; m0_wr = 1; m0_addr = 21'h000C0; m0_wr_data = 32'h5;
        next_cycle();
        chk("t1_cs", {31'd0, mmio_cs}, 32'd1);
        chk("t1_wr", {31'd0, mmio_wr}, 32'd1);
        chk("t1_rd", {31'd0, mmio_rd}, 32'd0);
        chk("t1_addr", {11'd0, mmio_addr}, 32'h000C0);
        chk("t1_wdata", mmio_wr_data, 32'h5);
        chk("t1_grant", {30'd0, grant}, 32'd1);
        m0_addr = 21'h1FFFF; m0_wr_data = 32'h99;   // ignored after grant
        next_cycle();
        chk("t1_ack", {31'd0, m0_ack}, 32'd1);
        chk("t1_addr_hold", {11'd0, mmio_addr}, 32'h000C0);
        m0_req = 0;
        next_cycle();
        chk("t1_cs_off", {31'd0, mmio_cs}, 32'd0);
        chk("t1_grant_off", {30'd0, grant}, 32'd0);

        // m1 read 0x180 returning 0x12345678.
        slave_data = 32'h12345678;
        m1_req = 1; m1_wr = 0; m1_addr = 21'h00180;
        next_cycle();
        chk("t2_rd", {31'd0, mmio_rd}, 32'd1);
        chk("t2_grant", {30'd0, grant}, 32'd2);
        next_cycle();
        chk("t2_ack", {31'd0, m1_ack}, 32'd1);
        chk("t2_rd1", m1_rd_data, 32'h12345678);
        chk("t2_rd0", m0_rd_data, 32'd0);
        m1_req = 0; slave_data = 32'h0BAD_0BAD;
        next_cycle(2);
        chk("t2_rd1_hold", m1_rd_data, 32'h12345678);

        // Reset, then both request at once: m0 first, m1 next.
        reset = 0; next_cycle(); reset = 1; next_cycle();
        m0_req = 1; m0_wr = 1; m0_addr = 21'h10; m0_wr_data = 32'h11;
        m1_req = 1; m1_wr = 1; m1_addr = 21'h20; m1_wr_data = 32'h22;
        next_cycle();
        chk("t3_g0", {30'd0, grant}, 32'd1);
        next_cycle();
        chk("t3_ack0", {31'd0, m0_ack}, 32'd1);
        m0_req = 0;
        next_cycle(2);
        chk("t3_cs1", {31'd0, mmio_cs}, 32'd1);
        chk("t3_g1", {30'd0, grant}, 32'd2);
        chk("t3_addr1", {11'd0, mmio_addr}, 32'h20);
        next_cycle();
        chk("t3_ack1", {31'd0, m1_ack}, 32'd1);
        m1_req = 0;
        next_cycle();

        // m0 holds req, m1 requests once: order m0, m1, m0.
        m0_req = 1; m1_req = 1;
        next_cycle();
        chk("t4_g_a", {30'd0, grant}, 32'd1);
        next_cycle(3);
        chk("t4_g_b", {30'd0, grant}, 32'd2);
        next_cycle();
        chk("t4_ack1", {31'd0, m1_ack}, 32'd1);
        m1_req = 0;
        next_cycle(2);
        chk("t4_g_c", {30'd0, grant}, 32'd1);
        next_cycle();
        m0_req = 0;
        next_cycle();

        // Reset in the ISSUE cycle of an m0 read aborts it.
        slave_data = 32'h77;
        m0_req = 1; m0_wr = 0; m0_addr = 21'h40;
        next_cycle();
        chk("t5_cs_pre", {31'd0, mmio_cs}, 32'd1);
        reset = 0;
        #1;
        chk("t5_cs_async", {31'd0, mmio_cs}, 32'd0);
        chk("t5_grant_async", {30'd0, grant}, 32'd0);
        next_cycle();
        chk("t5_no_ack", {31'd0, m0_ack}, 32'd0);
        chk("t5_rd0", m0_rd_data, 32'd0);
        // Re-request with both masters; rr back at 0 means m0 wins.
        m1_req = 1; m1_wr = 0; m1_addr = 21'h50;
        reset = 1;
        next_cycle();
        chk("t5_g0", {30'd0, grant}, 32'd1);
        next_cycle();
        chk("t5_ack0", {31'd0, m0_ack}, 32'd1);
        chk("t5_rd0_ok", m0_rd_data, 32'h77);
        m0_req = 0; slave_data = 32'hAAAA;
        next_cycle(3);
        chk("t5_ack1", {31'd0, m1_ack}, 32'd1);
        chk("t5_rd1", m1_rd_data, 32'hAAAA);
        m1_req = 0;
        next_cycle();

        // m1 write leaves m1_rd_data; m0 read only touches m0_rd_data.
        m1_req = 1; m1_wr = 1; m1_addr = 21'h60; m1_wr_data = 32'h1234;
        next_cycle(2);
        chk("t6_ack1", {31'd0, m1_ack}, 32'd1);
        chk("t6_rd1_w", m1_rd_data, 32'hAAAA);
        m1_req = 0;
        next_cycle();
        slave_data = 32'h5555;
        m0_req = 1; m0_wr = 0; m0_addr = 21'h70;
        next_cycle(2);
        chk("t6_ack0", {31'd0, m0_ack}, 32'd1);
        chk("t6_rd0", m0_rd_data, 32'h5555);
        chk("t6_rd1", m1_rd_data, 32'hAAAA);
        m0_req = 0;
        next_cycle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mmio_bus_arbiter.md
# mmio_bus_arbiter

Two-master arbiter that shares the single FPro MMIO bus in front of the MMIO subsystem (timer, UART, LED/switch GPIO, user slots) between two requesters, e.g. the processor core and a debug/DMA bridge. Each master uses a req/ack handshake. The arbiter grants round-robin, issues exactly one single-cycle FPro bus transaction per grant, and returns registered read data. It sits between the masters and the MMIO controller and is the only driver of the FPro MMIO bus.

## Interface
Parameters:
- AW, 21, FPro MMIO address width.
- DW, 32, FPro data width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset).
- m0_req / m1_req  in  1  master request; held high with stable command fields until ack.
- m0_wr / m1_wr  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  AW  target MMIO address.
- m0_wr_data / m1_wr_data  in  DW  write data.
- m0_ack / m1_ack  out  1  one-cycle completion pulse.
- m0_rd_data / m1_rd_data  out  DW  last read result for that master; registered.
- mmio_cs  out  1  FPro chip select.
- mmio_wr / mmio_rd  out  1  FPro write/read strobes.
- mmio_addr  out  AW  FPro address.
- mmio_wr_data  out  DW  FPro write data.
- mmio_rd_data  in  DW  FPro read data, valid combinationally while mmio_cs and mmio_rd are high.
- grant  out  2  one-hot owner of the current transaction; 00 when idle.
- busy  out  1  high in ISSUE and ACK.

## Operation
- FSM states: IDLE, ISSUE, ACK. Round-robin pointer rr: 0 prefers m0, 1 prefers m1.
- IDLE:
  - If no req, stay.
  - If exactly one req, grant it.
  - If both req, grant the master selected by rr.
  - On grant, latch wr/addr/wr_data into the output command registers, set grant, and go to ISSUE.
- ISSUE (exactly one cycle):
  - mmio_cs=1; mmio_wr=latched wr; mmio_rd=~latched wr; address and data from the latch.
  - On a read, capture mmio_rd_data into the granted master's rd_data register at the cycle end.
  - Go to ACK.
- ACK (one cycle):
  - Granted master's ack=1.
  - rr set to the other master.
  - Go to IDLE; grant is cleared on entry to IDLE.
- A write never changes mi_rd_data. A read by one master never changes the other master's rd_data.
- If a master keeps req high in the cycle after its ack, that is a new request and is arbitrated normally in IDLE.
- Outside ISSUE: mmio_cs/wr/rd = 0; mmio_addr and mmio_wr_data hold their latched values.
- Request fields are sampled only at the IDLE→ISSUE edge. Changes after the grant are ignored.

## Timing
- Reset (reset low, async): state=IDLE, rr=0, grant=00, busy=0, all acks 0, mmio_cs/wr/rd 0, mmio_addr 0, mmio_wr_data 0, m0/m1_rd_data 0. Outputs go to these values immediately, without waiting for a clock edge.
- Reset during ISSUE or ACK: the transaction is aborted, no ack is produced, and the master must re-request.
- Latency: req high in cycle 0 (IDLE) → mmio_cs in cycle 1 → ack and valid rd_data in cycle 2.
- Throughput: at most one transaction per 3 cycles.
- All outputs are registered, with no combinational path from any input to any output.
- Fairness: with both masters requesting continuously, grants alternate m0, m1, m0, ... Neither master waits more than one other transaction.

## Test plan
- m0 write, addr 0x000C0, data 0x5, m1 idle → cycle 1: mmio_cs=1, mmio_wr=1, mmio_rd=0, mmio_addr=0x000C0, mmio_wr_data=0x5, grant=01; cycle 2: m0_ack=1; cycle 3: mmio_cs=0, grant=00.
- m1 read, addr 0x00180, mmio_rd_data=0x12345678 during ISSUE → m1_rd_data=0x12345678 from the ack cycle onward and held afterward; m0_rd_data stays 0.
- Both masters request in the same cycle right after reset → m0 served first (ack in cycle 2), then m1 (mmio_cs in cycle 4, ack in cycle 5).
- m0 holds req high continuously, m1 requests once → order m0, m1, m0; m1 is granted on the IDLE immediately after m0's first ack.
- Reset driven low in the ISSUE cycle of an m0 read → mmio_cs falls in the same cycle, no m0_ack, rr=0, m0_rd_data=0. After reset is released, a re-request completes normally.
- m1_rd_data preloaded 0xAAAA by a read, then m1 write, then m0 read of 0x5555 → m1_rd_data remains 0xAAAA; m0_rd_data=0x5555.
